// File: rtl/trace_plot_pkg.sv
// rtl/trace_plot_pkg.sv - shared constants for the strip-chart trace plotter
package trace_plot_pkg;

   localparam int H_PIXELS = 640;
   localparam int V_PIXELS = 480;
   localparam int Y_SHIFT  = 2;

   // Each trace owns half the screen height; the centre line is its zero.
   localparam int TOP_CENTER = V_PIXELS / 4;        // 120
   localparam int TOP_MAX    = V_PIXELS / 2 - 1;    // 239
   localparam int BOT_MIN    = V_PIXELS / 2;        // 240
   localparam int BOT_CENTER = (3 * V_PIXELS) / 4;  // 360
   localparam int BOT_MAX    = V_PIXELS - 1;        // 479

   localparam logic [7:0] COLOR_X1 = 8'hE0;
   localparam logic [7:0] COLOR_X2 = 8'h1C;
   localparam logic [7:0] COLOR_BG = 8'h00;

   // Plotter sequencer states.
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ERASE1  = 3'd1;
   localparam logic [2:0] ST_ERASE2  = 3'd2;
   localparam logic [2:0] ST_DRAW1   = 3'd3;
   localparam logic [2:0] ST_DRAW2   = 3'd4;
   localparam logic [2:0] ST_ADVANCE = 3'd5;

endpackage

// File: rtl/trace_y_map.sv
// rtl/trace_y_map.sv - signed sample to screen row: shift, offset, clamp
module trace_y_map #(
   parameter int Y_SHIFT = 2,
   parameter int OFFSET  = 120,
   parameter int LO      = 0,
   parameter int HI      = 239
) (
   input  logic signed [9:0] x,
   output logic        [8:0] y
);

   // 12 bits covers offset (up to 479) minus a shifted 10-bit sample with headroom.
   localparam logic signed [11:0] OFFSET_S = 12'(OFFSET);
   localparam logic signed [11:0] LO_S     = 12'(LO);
   localparam logic signed [11:0] HI_S     = 12'(HI);

   logic signed [11:0] x_ext;
   logic signed [11:0] shifted;
   logic signed [11:0] row;

   assign x_ext = {{2{x[9]}}, x};

   // Screen rows grow downward, so a positive sample moves the pixel up.
   always_comb begin
      shifted = x_ext >>> Y_SHIFT;
      row     = OFFSET_S - shifted;
      if (row < LO_S) begin
         y = LO_S[8:0];
      end else if (row > HI_S) begin
         y = HI_S[8:0];
      end else begin
         y = row[8:0];
      end
   end

endmodule

// File: rtl/trace_plotter.sv
// rtl/trace_plotter.sv - scrolling two-trace strip chart writer into a pixel framebuffer
module trace_plotter
   import trace_plot_pkg::*;
#(
   parameter int         H_PIXELS = trace_plot_pkg::H_PIXELS,
   parameter int         Y_SHIFT  = trace_plot_pkg::Y_SHIFT,
   parameter logic [7:0] COLOR_X1 = trace_plot_pkg::COLOR_X1,
   parameter logic [7:0] COLOR_X2 = trace_plot_pkg::COLOR_X2,
   parameter logic [7:0] COLOR_BG = trace_plot_pkg::COLOR_BG
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sample_valid,
   input  logic signed [9:0] x1,
   input  logic signed [9:0] x2,
   output logic              wr_req,
   output logic        [9:0] wr_x,
   output logic        [8:0] wr_y,
   output logic        [7:0] wr_data,
   input  logic              wr_ack,
   output logic              busy,
   output logic        [9:0] col,
   output logic              frame_wrap,
   output logic              overrun
);

   localparam logic [9:0] LAST_COL = 10'(H_PIXELS - 1);

   logic [2:0]  state;
   logic        first_lap;
   logic [8:0]  y1;
   logic [8:0]  y2;
   logic [8:0]  y1_q;
   logic [8:0]  y2_q;
   logic [17:0] hist_rd;

   // Previously drawn rows per column, packed as {y2, y1}; first_lap masks stale contents.
   logic [17:0] hist [0:H_PIXELS-1];

   trace_y_map #(
      .Y_SHIFT (Y_SHIFT),
      .OFFSET  (TOP_CENTER),
      .LO      (0),
      .HI      (TOP_MAX)
   ) u_map_top (
      .x (x1),
      .y (y1)
   );

   trace_y_map #(
      .Y_SHIFT (Y_SHIFT),
      .OFFSET  (BOT_CENTER),
      .LO      (BOT_MIN),
      .HI      (BOT_MAX)
   ) u_map_bot (
      .x (x2),
      .y (y2)
   );

   assign hist_rd = hist[col];
   assign busy    = (state != ST_IDLE);

   // Record the rows just drawn so the next lap can erase them.
   always_ff @(posedge clk) begin
      if (state == ST_ADVANCE) begin
         hist[col] <= {y2_q, y1_q};
      end
   end

   // Sequencer: accept a sample, issue erase/draw writes with req/ack, then advance the column.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         first_lap  <= 1'b1;
         col        <= '0;
         wr_req     <= 1'b0;
         wr_x       <= '0;
         wr_y       <= '0;
         wr_data    <= '0;
         frame_wrap <= 1'b0;
         overrun    <= 1'b0;
         y1_q       <= '0;
         y2_q       <= '0;
      end else begin
         frame_wrap <= 1'b0;
         if (sample_valid && state != ST_IDLE) begin
            overrun <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (sample_valid) begin
                  y1_q   <= y1;
                  y2_q   <= y2;
                  wr_req <= 1'b1;
                  wr_x   <= col;
                  if (first_lap) begin
                     state   <= ST_DRAW1;
                     wr_y    <= y1;
                     wr_data <= COLOR_X1;
                  end else begin
                     state   <= ST_ERASE1;
                     wr_y    <= hist_rd[8:0];
                     wr_data <= COLOR_BG;
                  end
               end
            end
            ST_ERASE1: begin
               if (wr_ack) begin
                  state <= ST_ERASE2;
                  wr_y  <= hist_rd[17:9];
               end
            end
            ST_ERASE2: begin
               if (wr_ack) begin
                  state   <= ST_DRAW1;
                  wr_y    <= y1_q;
                  wr_data <= COLOR_X1;
               end
            end
            ST_DRAW1: begin
               if (wr_ack) begin
                  state   <= ST_DRAW2;
                  wr_y    <= y2_q;
                  wr_data <= COLOR_X2;
               end
            end
            ST_DRAW2: begin
               if (wr_ack) begin
                  state  <= ST_ADVANCE;
                  wr_req <= 1'b0;
               end
            end
            ST_ADVANCE: begin
               state <= ST_IDLE;
               if (col == LAST_COL) begin
                  col        <= '0;
                  first_lap  <= 1'b0;
                  frame_wrap <= 1'b1;
               end else begin
                  col <= col + 10'd1;
               end
            end
            default: begin
               state  <= ST_IDLE;
               wr_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trace_plotter.sv
// tb/tb_trace_plotter.sv - randomized self-checking bench for trace_plotter
module tb_trace_plotter;

   logic              clk;
   logic              rst;
   logic              sample_valid;
   logic signed [9:0] x1;
   logic signed [9:0] x2;
   logic              wr_req;
   logic        [9:0] wr_x;
   logic        [8:0] wr_y;
   logic        [7:0] wr_data;
   logic              wr_ack;
   logic              busy;
   logic        [9:0] col;
   logic              frame_wrap;
   logic              overrun;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int m_col   = 0;
   bit m_first = 1;
   bit m_over  = 0;
   int m_h1 [640];
   int m_h2 [640];

   trace_plotter dut (
      .clk          (clk),
      .reset        (rst),
      .sample_valid (sample_valid),
      .x1           (x1),
      .x2           (x2),
      .wr_req       (wr_req),
      .wr_x         (wr_x),
      .wr_y         (wr_y),
      .wr_data      (wr_data),
      .wr_ack       (wr_ack),
      .busy         (busy),
      .col          (col),
      .frame_wrap   (frame_wrap),
      .overrun      (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Row for a sample: floor-divide by 4, subtract from the half's centre, clamp to the half.
   function automatic int ref_row(input int x, input int center, input int lo, input int hi);
      int s;
      int r;
      s = (x - (((x % 4) + 4) % 4)) / 4;
      r = center - s;
      if (r < lo) r = lo;
      if (r > hi) r = hi;
      return r;
   endfunction

   task automatic do_sample(input int a, input int b, input bit full_ack, input int stall_idx);
      int ex [4];
      int ey [4];
      int ed [4];
      int n;
      int r1;
      int r2;
      int col_before;
      bit exp_wrap;
      bit was_first;
      int widx;
      int busy_cnt;
      int wraps;
      int stall_left;
      int hx;
      int hy;
      int hd;
      bit done;
      bit ack;

      r1 = ref_row(a, 120, 0, 239);
      r2 = ref_row(b, 360, 240, 479);
      col_before = m_col;
      was_first  = m_first;
      n = 0;
      if (!m_first) begin
         ex[n] = m_col; ey[n] = m_h1[m_col]; ed[n] = 0; n++;
         ex[n] = m_col; ey[n] = m_h2[m_col]; ed[n] = 0; n++;
      end
      ex[n] = m_col; ey[n] = r1; ed[n] = 8'hE0; n++;
      ex[n] = m_col; ey[n] = r2; ed[n] = 8'h1C; n++;
      m_h1[m_col] = r1;
      m_h2[m_col] = r2;
      exp_wrap = (m_col == 639);
      if (exp_wrap) begin
         m_col   = 0;
         m_first = 0;
      end else begin
         m_col = m_col + 1;
      end
      if (stall_idx >= 0) m_over = 1;

      @(negedge clk);
      sample_valid = 1'b1;
      x1 = 10'(a);
      x2 = 10'(b);
      @(negedge clk);
      sample_valid = 1'b0;

      widx = 0; busy_cnt = 0; wraps = 0; stall_left = 5; done = 0;
      hx = 0; hy = 0; hd = 0;
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         if (frame_wrap) wraps++;
         if (!busy) begin
            done = 1;
         end else begin
            busy_cnt++;
            if (wr_req && widx == stall_idx && stall_left > 0) begin
               if (stall_left == 5) begin
                  hx = wr_x; hy = wr_y; hd = wr_data;
               end else begin
                  check_eq("stall_wr_x", wr_x, hx);
                  check_eq("stall_wr_y", wr_y, hy);
                  check_eq("stall_wr_data", wr_data, hd);
                  check_eq("stall_wr_req", wr_req, 1);
                  check_eq("stall_col", col, col_before);
               end
               if (stall_left == 3) begin
                  sample_valid = 1'b1;
                  x1 = 10'(a + 100);
                  x2 = 10'(b - 100);
               end else begin
                  sample_valid = 1'b0;
               end
               wr_ack = 1'b0;
               stall_left--;
            end else if (wr_req) begin
               sample_valid = 1'b0;
               ack = full_ack ? 1'b1 : ($urandom_range(0, 3) != 0);
               wr_ack = ack;
               if (ack) begin
                  if (widx < n) begin
                     check_eq("wr_x", wr_x, ex[widx]);
                     check_eq("wr_y", wr_y, ey[widx]);
                     check_eq("wr_data", wr_data, ed[widx]);
                  end
                  widx++;
               end
            end else begin
               sample_valid = 1'b0;
               wr_ack = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
         end
      end
      check_eq("done_in_budget", done, 1);
      check_eq("write_count", widx, n);
      check_eq("col", col, m_col);
      check_eq("frame_wrap_count", wraps, exp_wrap ? 1 : 0);
      check_eq("overrun", overrun, m_over);
      if (full_ack && stall_idx < 0) begin
         check_eq("busy_cycles", busy_cnt, was_first ? 3 : 5);
      end
   endtask

   initial begin
      int ra;
      int rb;
      rst = 1'b1;
      sample_valid = 1'b0;
      x1 = '0;
      x2 = '0;
      wr_ack = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_wr_req", wr_req, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_col", col, 0);
      check_eq("rst_frame_wrap", frame_wrap, 0);
      check_eq("rst_overrun", overrun, 0);
      check_eq("rst_wr_x", wr_x, 0);
      check_eq("rst_wr_y", wr_y, 0);
      check_eq("rst_wr_data", wr_data, 0);
      rst = 1'b0;

      // First lap: known points including both clamp limits
      do_sample(0, 0, 1, -1);
      do_sample(150, 300, 1, -1);
      do_sample(511, -512, 1, -1);

      // Fill the rest of the lap with random samples and random backpressure
      for (int i = 0; i < 637; i++) begin
         ra = int'($urandom_range(0, 1023)) - 512;
         rb = int'($urandom_range(0, 1023)) - 512;
         do_sample(ra, rb, 0, -1);
      end
      check_eq("lap_col_zero", col, 0);

      // Second lap: erase of column 0 then draw
      do_sample(0, 0, 1, -1);
      for (int i = 0; i < 5; i++) begin
         ra = int'($urandom_range(0, 1023)) - 512;
         rb = int'($urandom_range(0, 1023)) - 512;
         do_sample(ra, rb, 0, -1);
      end

      // Backpressure in DRAW1 with a dropped sample in the middle
      ra = int'($urandom_range(0, 1023)) - 512;
      rb = int'($urandom_range(0, 1023)) - 512;
      do_sample(ra, rb, 1, 2);

      // Reset asserted while DRAW2 waits for ack
      @(negedge clk);
      sample_valid = 1'b1;
      x1 = 10'(40);
      x2 = 10'(-40);
      wr_ack = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (3) @(negedge clk);
      wr_ack = 1'b0;
      check_eq("pre_reset_wr_data", wr_data, 8'h1C);
      check_eq("pre_reset_wr_req", wr_req, 1);
      #1 rst = 1'b1;
      #1;
      check_eq("async_rst_wr_req", wr_req, 0);
      check_eq("async_rst_busy", busy, 0);
      check_eq("async_rst_col", col, 0);
      check_eq("async_rst_overrun", overrun, 0);
      @(negedge clk);
      rst = 1'b0;
      m_col = 0;
      m_first = 1;
      m_over = 0;

      // After reset: no erase despite stale history
      for (int i = 0; i < 3; i++) begin
         ra = int'($urandom_range(0, 1023)) - 512;
         rb = int'($urandom_range(0, 1023)) - 512;
         do_sample(ra, rb, 1, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
